// File: rtl/mem_access_ctrl_pkg.sv
// Shared encodings for the CPU data-memory access controller: access sizes,
// controller states and the alignment rule used when a request is accepted.
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RD   = 2'd1;
  localparam state_t ST_WR   = 2'd2;
  localparam state_t ST_RSP  = 2'd3;

  // Bytes are never misaligned; halves need an even address, words a multiple of 4.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    return ((size == SIZE_HALF) && lo[0]) || ((size == SIZE_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU request/response handshake plus the data-memory port of the controller.
// The master side is the CPU and memory environment; the slave side is the controller.
interface mem_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wr;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] MemAddr;
  logic [31:0] MemData;
  logic        MemWr;
  logic [31:0] MemRdata;

  modport master (
    output req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, MemRdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, MemAddr, MemData, MemWr
  );

  modport slave (
    input  req_valid, req_wr, req_size, req_signed, req_addr, req_wdata, MemRdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, MemAddr, MemData, MemWr
  );
endinterface

// File: rtl/mem_access_ctrl_lane.sv
// Little-endian lane logic: merges sub-word store data into a read word and
// extracts and extends sub-word load data from a read word.
module lane_unit
  import mem_access_pkg::*;
(
  input  logic [31:0] rword_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [31:0] merged_o,
  output logic [31:0] load_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    merged_o = rword_i;
    case (size_i)
      SIZE_BYTE: merged_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      SIZE_HALF: begin
        if (lane_i[1]) merged_o[31:16] = wdata_i[15:0];
        else           merged_o[15:0]  = wdata_i[15:0];
      end
      default:   merged_o = wdata_i;
    endcase
  end

  assign byte_sel = rword_i[{lane_i, 3'b000} +: 8];
  assign half_sel = lane_i[1] ? rword_i[31:16] : rword_i[15:0];

  always_comb begin
    case (size_i)
      SIZE_BYTE: load_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
      SIZE_HALF: load_o = {{16{signed_i & half_sel[15]}}, half_sel};
      default:   load_o = rword_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller between a CPU request port and a single-port word DM.
// Sub-word stores are done as read-modify-write of the containing word.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int unsigned DM_WORDS = 1024
) (
  input logic            clk,
  input logic            reset,
  mem_access_ctrl_if.slave bus
);

  state_t      state_q, state_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic        signed_q, signed_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic        req_err;
  logic        in_mem;
  logic [31:0] merged_word;
  logic [31:0] load_word;

  assign req_err = (bus.req_size == SIZE_RSVD)
                || is_misaligned(bus.req_size, bus.req_addr[1:0])
                || ({2'b00, bus.req_addr[31:2]} >= DM_WORDS);

  // Faulting requests skip the DM entirely; only word stores skip the read.
  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    size_d   = size_q;
    signed_d = signed_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          wr_d     = bus.req_wr;
          size_d   = bus.req_size;
          signed_d = bus.req_signed;
          addr_d   = bus.req_addr;
          wdata_d  = bus.req_wdata;
          err_d    = req_err;
          if (req_err)
            state_d = ST_RSP;
          else if (bus.req_wr && (bus.req_size == SIZE_WORD))
            state_d = ST_WR;
          else
            state_d = ST_RD;
        end
      end
      ST_RD: begin
        rdata_d = bus.MemRdata;
        state_d = wr_q ? ST_WR : ST_RSP;
      end
      ST_WR:   state_d = ST_RSP;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      wr_q     <= 1'b0;
      size_q   <= SIZE_BYTE;
      signed_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  lane_unit u_lane (
    .rword_i  (rdata_q),
    .wdata_i  (wdata_q),
    .lane_i   (addr_q[1:0]),
    .size_i   (size_q),
    .signed_i (signed_q),
    .merged_o (merged_word),
    .load_o   (load_word)
  );

  assign in_mem        = (state_q == ST_RD) || (state_q == ST_WR);
  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RSP);
  assign bus.rsp_err   = (state_q == ST_RSP) && err_q;
  assign bus.rsp_rdata = ((state_q == ST_RSP) && !err_q && !wr_q) ? load_word : 32'h0;
  assign bus.MemAddr   = in_mem ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus.MemWr     = (state_q == ST_WR);
  assign bus.MemData   = (state_q == ST_WR) ? merged_word : 32'h0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: a behavioural DM plus a word-array reference model
// that predicts latency, errors, load results and merged store words.
module tb_mem_access_ctrl;

  localparam int DMW = 64;

  logic clk;
  logic reset;
  logic dmInit;
  int   checks;
  int   errors;

  logic [31:0] dm        [DMW];
  logic [31:0] initWords [DMW];
  logic [31:0] refMem    [DMW];

  mem_access_ctrl_if bus();

  mem_access_ctrl #(.DM_WORDS(DMW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (dmInit) begin
      for (int i = 0; i < DMW; i++) dm[i] <= initWords[i];
    end else if (bus.MemWr) begin
      dm[bus.MemAddr[7:2]] <= bus.MemData;
    end
  end

  assign bus.MemRdata = dm[bus.MemAddr[7:2]];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic refErr(input logic [1:0] size, input logic [31:0] addr);
    return (size == 2'd3) || (size == 2'd1 && addr % 2 != 0)
        || (size == 2'd2 && addr % 4 != 0) || (addr / 4 >= DMW);
  endfunction

  function automatic logic [31:0] refLoad(input logic [1:0] size, input logic sgn, input logic [31:0] addr);
    logic [31:0] w, v;
    w = refMem[(addr / 4) % DMW];
    if (size == 2'd0) begin
      v = (w >> ((addr % 4) * 8)) & 32'hFF;
      if (sgn && v >= 32'h80) v = v | 32'hFFFFFF00;
    end else if (size == 2'd1) begin
      v = (w >> (((addr % 4) / 2) * 16)) & 32'hFFFF;
      if (sgn && v >= 32'h8000) v = v | 32'hFFFF0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] refStore(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] w, mask;
    int sh;
    w = refMem[(addr / 4) % DMW];
    if (size == 2'd0) begin
      mask = 32'hFF;   sh = (addr % 4) * 8;
    end else if (size == 2'd1) begin
      mask = 32'hFFFF; sh = ((addr % 4) / 2) * 16;
    end else begin
      mask = 32'hFFFFFFFF; sh = 0;
    end
    return (w & ~(mask << sh)) | ((wdata & mask) << sh);
  endfunction

  // One complete transaction; latency counts edges from the accepting edge.
  task automatic applyStimulus(input logic wr, input logic [1:0] size, input logic sgn,
                               input logic [31:0] addr, input logic [31:0] wdata);
    logic        expErr;
    int          expLat;
    logic [31:0] expData, expWord, seenData, seenAddr;
    int          lat, wrCycles;
    expErr  = refErr(size, addr);
    expLat  = expErr ? 1 : (!wr ? 2 : (size == 2'd2 ? 2 : 3));
    expData = (!expErr && !wr) ? refLoad(size, sgn, addr) : 32'h0;
    expWord = (!expErr && wr) ? refStore(size, addr, wdata) : 32'h0;
    seenData = 32'h0;
    seenAddr = 32'h0;
    @(negedge clk);
    checkOutput("req_ready idle", {31'h0, bus.req_ready}, 32'h1);
    bus.req_wr = wr; bus.req_size = size; bus.req_signed = sgn;
    bus.req_addr = addr; bus.req_wdata = wdata; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    wrCycles = 0;
    while (!bus.rsp_valid && lat < 8) begin
      if (bus.MemWr) begin
        wrCycles++;
        seenData = bus.MemData;
        seenAddr = bus.MemAddr;
      end
      @(posedge clk); #1;
      lat++;
    end
    checkOutput("latency", lat, expLat);
    checkOutput("rsp_err", {31'h0, bus.rsp_err}, {31'h0, expErr});
    checkOutput("rsp_rdata", bus.rsp_rdata, expData);
    checkOutput("MemWr in RSP", {31'h0, bus.MemWr}, 32'h0);
    checkOutput("write cycles", wrCycles, (wr && !expErr) ? 1 : 0);
    if (wr && !expErr) begin
      checkOutput("store MemData", seenData, expWord);
      checkOutput("store MemAddr", seenAddr, addr & ~32'h3);
      refMem[(addr / 4) % DMW] = expWord;
    end
    @(posedge clk); #1;
    checkOutput("rsp one cycle", {31'h0, bus.rsp_valid}, 32'h0);
  endtask

  task automatic backToBack();
    logic [31:0] expv [4];
    int          accCyc [4];
    logic [31:0] got [$];
    int          idx = 0;
    int          cyc = 0;
    for (int i = 0; i < 4; i++) expv[i] = refLoad(2'd2, 1'b0, 32'h10 + 4 * i);
    @(negedge clk);
    bus.req_wr = 1'b0; bus.req_size = 2'd2; bus.req_signed = 1'b0;
    bus.req_addr = 32'h10; bus.req_valid = 1'b1;
    while ((idx < 4 || got.size() < 4) && cyc < 40) begin
      logic acc;
      acc = 1'b0;
      if (bus.rsp_valid) got.push_back(bus.rsp_rdata);
      if (idx < 4 && bus.req_ready) begin
        accCyc[idx] = cyc;
        idx++;
        acc = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (acc) begin
        if (idx < 4) bus.req_addr = 32'h10 + 4 * idx;
        else         bus.req_valid = 1'b0;
      end
    end
    checkOutput("b2b accepts", idx, 4);
    checkOutput("b2b responses", got.size(), 4);
    for (int i = 1; i < idx; i++) checkOutput("b2b spacing", accCyc[i] - accCyc[i-1], 3);
    for (int i = 0; i < got.size() && i < 4; i++) checkOutput("b2b rdata", got[i], expv[i]);
    repeat (3) begin
      @(negedge clk);
      checkOutput("b2b no extra rsp", {31'h0, bus.rsp_valid}, 32'h0);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [1:0]  sz;
    checks = 0;
    errors = 0;
    reset = 1'b0;
    dmInit = 1'b1;
    bus.req_valid = 1'b0; bus.req_wr = 1'b0; bus.req_size = 2'd0;
    bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    for (int i = 0; i < DMW; i++) begin
      initWords[i] = $urandom;
      refMem[i] = initWords[i];
    end
    repeat (3) @(negedge clk);
    checkOutput("reset req_ready", {31'h0, bus.req_ready}, 32'h1);
    checkOutput("reset rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    checkOutput("reset rsp_rdata", bus.rsp_rdata, 32'h0);
    checkOutput("reset rsp_err", {31'h0, bus.rsp_err}, 32'h0);
    checkOutput("reset MemAddr", bus.MemAddr, 32'h0);
    checkOutput("reset MemData", bus.MemData, 32'h0);
    checkOutput("reset MemWr", {31'h0, bus.MemWr}, 32'h0);
    dmInit = 1'b0;
    reset = 1'b1;

    applyStimulus(1'b1, 2'd2, 1'b0, 32'h4, 32'h12345678);
    applyStimulus(1'b0, 2'd2, 1'b0, 32'h4, 32'h0);
    applyStimulus(1'b1, 2'd0, 1'b0, 32'h6, 32'h000000AB);
    checkOutput("rmw word", dm[1], 32'h12AB5678);

    applyStimulus(1'b1, 2'd2, 1'b0, 32'h8, 32'h0000F080);
    applyStimulus(1'b0, 2'd0, 1'b1, 32'h8, 32'h0);
    applyStimulus(1'b0, 2'd1, 1'b0, 32'h8, 32'h0);
    applyStimulus(1'b0, 2'd1, 1'b1, 32'h8, 32'h0);

    applyStimulus(1'b0, 2'd1, 1'b0, 32'h3, 32'h0);
    applyStimulus(1'b1, 2'd2, 1'b0, 32'h2, 32'hDEADBEEF);
    applyStimulus(1'b0, 2'd3, 1'b0, 32'h10, 32'h0);
    applyStimulus(1'b0, 2'd2, 1'b0, 4 * DMW, 32'h0);

    // Abort a byte store while it is in its write cycle.
    @(negedge clk);
    bus.req_wr = 1'b1; bus.req_size = 2'd0; bus.req_signed = 1'b0;
    bus.req_addr = 32'h5; bus.req_wdata = 32'h00000033; bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("MemWr before abort", {31'h0, bus.MemWr}, 32'h1);
    reset = 1'b0;
    #1;
    checkOutput("abort MemWr", {31'h0, bus.MemWr}, 32'h0);
    checkOutput("abort req_ready", {31'h0, bus.req_ready}, 32'h1);
    checkOutput("abort rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    checkOutput("abort MemAddr", bus.MemAddr, 32'h0);
    checkOutput("abort MemData", bus.MemData, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("abort no rsp", {31'h0, bus.rsp_valid}, 32'h0);
    end
    checkOutput("abort word kept", dm[1], refMem[1]);

    backToBack();

    for (int n = 0; n < 300; n++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = 4 * DMW + $urandom_range(0, 255);
      else                            a = $urandom_range(0, 4 * DMW - 1);
      if ($urandom_range(0, 4) != 0) begin
        if (sz == 2'd1) a = a & ~32'h1;
        if (sz == 2'd2) a = a & ~32'h3;
      end
      applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
    end

    @(negedge clk);
    for (int i = 0; i < DMW; i++) checkOutput("final DM word", dm[i], refMem[i]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter: DM_WORDS, default 1024, DM depth in 32-bit words; legal word index 0..DM_WORDS-1.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 reset  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  1  CPU access request.
REQ-006 req_ready  out  1  controller idle, request accepted on req_valid&req_ready.
REQ-007 req_wr  in  1  1=store, 0=load.
REQ-008 req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-009 req_signed  in  1  loads: 1 sign-extend, 0 zero-extend.
REQ-010 req_addr  in  32  byte address.
REQ-011 req_wdata  in  32  store data, right-aligned.
REQ-012 rsp_valid  out  1  one-cycle completion pulse.
REQ-013 rsp_rdata  out  32  load result; 0 for stores and errors.
REQ-014 rsp_err  out  1  valid with rsp_valid; misaligned, out-of-range or reserved size.
REQ-015 MemAddr  out  32  DM word address, always {addr[31:2],2'b00}.
REQ-016 MemData  out  32  DM write data.
REQ-017 MemWr  out  1  DM write enable; DM writes on the rising edge while MemWr=1.
REQ-018 MemRdata  in  32  DM combinational read data for MemAddr.

Function
REQ-019 The FSM SHALL use states IDLE, RD, WR, RSP; req_ready=1 only in IDLE.
REQ-020 On acceptance, the controller SHALL latch wr, size, signed, addr and wdata; req_* is ignored outside IDLE.
REQ-021 Error (half with addr[0]=1, word with addr[1:0]!=0, size 11, addr[31:2]>=DM_WORDS): IDLE->RSP, rsp_err=1, no DM cycle.
REQ-022 Load: IDLE->RD->RSP; in RD, MemAddr is driven, MemWr=0, and MemRdata is registered at the end of RD.
REQ-023 Word store: IDLE->WR->RSP; in WR, MemWr=1 and MemData=wdata.
REQ-024 Byte/half store: IDLE->RD->WR->RSP read-modify-write; in WR, MemData equals the read word with only the addressed lanes replaced (little-endian: byte lane addr[1:0], half lane addr[1]).
REQ-025 Load extraction: select byte lane addr[1:0] or half lane addr[1], extend per req_signed; word is passed unmodified.
REQ-026 RSP SHALL last exactly one cycle with rsp_valid=1, then return to IDLE; there is no response back-pressure.
REQ-027 Latency from the acceptance edge to rsp_valid: error 1, load 2, word store 2, sub-word store 3 cycles.
REQ-028 Outside RD/WR: MemWr=0, MemAddr=0, MemData=0.
REQ-029 MemWr SHALL be decoded from the state register only; it never depends combinationally on req_*.
REQ-030 A new request held with req_valid during RSP SHALL be accepted in the following IDLE cycle, not in RSP.

Reset
REQ-031 reset=0 SHALL immediately force IDLE and clear all latched request fields and read data.
REQ-032 Outputs under reset: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, MemAddr=0, MemData=0, MemWr=0.
REQ-033 Reset asserted during WR SHALL drop MemWr at once; the write is aborted and no response is issued.

Structure
REQ-034 Package mem_access_pkg SHALL hold SIZE_BYTE/HALF/WORD/RSVD encodings and the state enumeration.
REQ-035 Lane logic SHALL be one sub-module, lane_unit: combinational store-merge plus load-extract, instantiated once.

Verification
REQ-036 Word store addr 0x4, wdata 0x12345678 -> one WR cycle with MemAddr=0x4, MemWr=1; rsp_valid 2 cycles after accept; a later word load of 0x4 returns 0x12345678.
REQ-037 Word 0x4 = 0x12345678; byte store 0xAB at 0x6 -> RD then WR with MemData=0x12AB5678; rsp_valid at cycle 3.
REQ-038 Word 0x8 = 0x0000F080; signed byte load 0x8 -> 0xFFFFFF80; unsigned half load 0x8 -> 0x0000F080; signed half load 0x8 -> 0xFFFFF080.
REQ-039 Half load at 0x3, word store at 0x2, size 11 and addr 4*DM_WORDS -> each gives rsp_err=1 one cycle after accept, MemWr never 1.
REQ-040 reset=0 asserted mid-WR of a byte store -> MemWr falls in the same cycle, the DM word is unchanged, no rsp_valid, and req_ready=1.
REQ-041 Back-to-back req_valid held high for 4 word loads -> each accepted only in IDLE; 3-cycle request spacing; no request is lost or duplicated.
